// File: rtl/slv_fifo_mailbox_if.sv
// slv_fifo_mailbox_if: data-memory bus between CPU master and mailbox slave
interface slv_fifo_mailbox_if;
  logic [7:0] mst2slv_addr;
  logic       mst2slv_wr;
  logic       mst2slv_rd;
  logic [7:0] mst2slv_data;
  logic [7:0] slv2mst_data;
  modport master (output mst2slv_addr, mst2slv_wr, mst2slv_rd, mst2slv_data, input slv2mst_data);
  modport slave (input mst2slv_addr, mst2slv_wr, mst2slv_rd, mst2slv_data, output slv2mst_data);
endinterface

// File: rtl/slv_fifo_mailbox.sv
// slv_fifo_mailbox: memory-mapped byte FIFO mailbox with threshold interrupt
module slv_fifo_mailbox #(
  parameter logic [7:0] BASEADDR   = 8'hA0,
  parameter int         DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  slv_fifo_mailbox_if.slave   bus,
  output logic                irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] count;
  logic [3:0] thr;
  logic [4:0] cnt5;
  logic [1:0] ra;
  logic [7:0] d;
  logic ie, ovf, udf, sel, wr_en, rd_en, empty, full, push, pop, flush;
  assign sel = bus.mst2slv_addr[7:2] == BASEADDR[7:2];
  assign ra = bus.mst2slv_addr[1:0];
  assign d = bus.mst2slv_data;
  // a simultaneous write wins; the read is suppressed entirely
  assign wr_en = sel & bus.mst2slv_wr;
  assign rd_en = sel & bus.mst2slv_rd & ~bus.mst2slv_wr;
  assign empty = count == '0;
  assign full = count == (DEPTH_LOG2+1)'(DEPTH);
  assign cnt5 = 5'(count);
  assign push = wr_en & (ra == 2'd0) & ~full;
  assign pop = rd_en & (ra == 2'd0) & ~empty;
  assign flush = wr_en & (ra == 2'd2) & d[1];
  assign bus.slv2mst_data = !rd_en ? 8'd0 :
                            ra == 2'd0 ? (empty ? 8'd0 : mem[rd_ptr]) :
                            ra == 2'd1 ? {cnt5, irq, full, empty} :
                            ra == 2'd2 ? {thr, 3'b000, ie} : {6'd0, udf, ovf};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ie <= 1'b0;
      thr <= 4'd0;
      ovf <= 1'b0;
      udf <= 1'b0;
      irq <= 1'b0;
    end else begin
      irq <= ie & (cnt5 > {1'b0, thr});
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      end
      if (wr_en & (ra == 2'd2)) begin
        ie <= d[0];
        thr <= d[7:4];
      end
      if (wr_en & (ra == 2'd0) & full) ovf <= 1'b1;
      else if (wr_en & (ra == 2'd3) & d[0]) ovf <= 1'b0;
      if (rd_en & (ra == 2'd0) & empty) udf <= 1'b1;
      else if (wr_en & (ra == 2'd3) & d[1]) udf <= 1'b0;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= d;
endmodule

// File: tb/tb_slv_fifo_mailbox.sv
// tb_slv_fifo_mailbox: directed and random bus traffic against a queue-based model
module tb_slv_fifo_mailbox;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];
  logic m_ie = 1'b0, m_ovf = 1'b0, m_udf = 1'b0, m_irq = 1'b0;
  logic [3:0] m_thr = 4'd0;
  logic [7:0] g;
  slv_fifo_mailbox_if bus();
  slv_fifo_mailbox #(.BASEADDR(8'hA0), .DEPTH_LOG2(4)) dut (.clk(clk), .rst(rst), .bus(bus), .irq(irq));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_ie = 0; m_ovf = 0; m_udf = 0; m_irq = 0; m_thr = 0;
  endtask
  task automatic op(input string tag, input logic [7:0] a, input logic w, input logic r,
                    input logic [7:0] d, output logic [7:0] got);
    logic [7:0] e;
    logic nirq;
    int n;
    @(negedge clk);
    bus.mst2slv_addr = a; bus.mst2slv_wr = w; bus.mst2slv_rd = r; bus.mst2slv_data = d;
    #1 got = bus.slv2mst_data;
    n = q.size();
    e = 8'd0;
    if (a >= 8'hA0 && a <= 8'hA3 && r && !w) begin
      if (a == 8'hA0) e = n ? q[0] : 8'd0;
      else if (a == 8'hA1) e = {5'(n), m_irq, n == 16, n == 0};
      else if (a == 8'hA2) e = {m_thr, 3'b000, m_ie};
      else e = {6'd0, m_udf, m_ovf};
    end
    chk(tag, got, e);
    nirq = m_ie && (n > m_thr);
    @(posedge clk);
    #1;
    if (a >= 8'hA0 && a <= 8'hA3 && w) begin
      if (a == 8'hA0) begin
        if (n == 16) m_ovf = 1; else q.push_back(d);
      end else if (a == 8'hA2) begin
        m_ie = d[0]; m_thr = d[7:4];
        if (d[1]) q.delete();
      end else if (a == 8'hA3) begin
        if (d[0]) m_ovf = 0;
        if (d[1]) m_udf = 0;
      end
    end else if (a == 8'hA0 && r) begin
      if (n == 0) m_udf = 1; else void'(q.pop_front());
    end
    m_irq = nirq;
    chk({tag, "_irq"}, {7'd0, irq}, {7'd0, m_irq});
    bus.mst2slv_wr = 0; bus.mst2slv_rd = 0;
  endtask
  task automatic push(input logic [7:0] d);
    logic [7:0] x;
    op("push", 8'hA0, 1, 0, d, x);
  endtask
  task automatic idle();
    logic [7:0] x;
    op("idle", 8'h00, 0, 0, 8'h00, x);
  endtask
  initial begin
    bus.mst2slv_addr = 0; bus.mst2slv_wr = 0; bus.mst2slv_rd = 0; bus.mst2slv_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    chk("rst_irq", {7'd0, irq}, 8'd0);
    op("rst_status", 8'hA1, 0, 1, 0, g); chk("rst_status_c", g, 8'h01);
    op("rst_ctrl", 8'hA2, 0, 1, 0, g); chk("rst_ctrl_c", g, 8'h00);
    op("rst_flags", 8'hA3, 0, 1, 0, g); chk("rst_flags_c", g, 8'h00);
    op("unsel_9f", 8'h9F, 0, 1, 0, g); chk("unsel_9f_c", g, 8'h00);
    op("unsel_a4", 8'hA4, 0, 1, 0, g); chk("unsel_a4_c", g, 8'h00);
    push(8'h11); push(8'h22); push(8'h33);
    op("st3", 8'hA1, 0, 1, 0, g); chk("st3_c", g, 8'h18);
    op("pop11", 8'hA0, 0, 1, 0, g); chk("pop11_c", g, 8'h11);
    op("pop22", 8'hA0, 0, 1, 0, g); chk("pop22_c", g, 8'h22);
    op("pop33", 8'hA0, 0, 1, 0, g); chk("pop33_c", g, 8'h33);
    op("st_empty", 8'hA1, 0, 1, 0, g); chk("st_empty_c", g, 8'h01);
    for (int i = 1; i <= 17; i++) push(8'(i));
    op("st_full", 8'hA1, 0, 1, 0, g); chk("st_full_c", g, 8'h82);
    op("ovf", 8'hA3, 0, 1, 0, g); chk("ovf_c", g, 8'h01);
    op("ovf_clr", 8'hA3, 1, 0, 8'h01, g);
    op("ovf_chk", 8'hA3, 0, 1, 0, g); chk("ovf_chk_c", g, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      op("drain", 8'hA0, 0, 1, 0, g); chk("drain_c", g, 8'(i));
    end
    op("no17", 8'hA1, 0, 1, 0, g); chk("no17_c", g, 8'h01);
    op("udf_pop", 8'hA0, 0, 1, 0, g); chk("udf_pop_c", g, 8'h00);
    op("udf", 8'hA3, 0, 1, 0, g); chk("udf_c", g, 8'h02);
    op("udf_st", 8'hA1, 0, 1, 0, g); chk("udf_st_c", g, 8'h01);
    op("udf_clr", 8'hA3, 1, 0, 8'h02, g);
    op("wr_rd", 8'hA0, 1, 1, 8'h5A, g); chk("wr_rd_c", g, 8'h00);
    op("wr_rd_pop", 8'hA0, 0, 1, 0, g); chk("wr_rd_pop_c", g, 8'h5A);
    op("ctrl21", 8'hA2, 1, 0, 8'h21, g);
    push(8'h01); push(8'h02); idle();
    chk("irq_2", {7'd0, irq}, 8'd0);
    push(8'h03);
    chk("irq_3_edge", {7'd0, irq}, 8'd0);
    idle();
    chk("irq_3_next", {7'd0, irq}, 8'd1);
    op("irq_pop", 8'hA0, 0, 1, 0, g);
    idle();
    chk("irq_after_pop", {7'd0, irq}, 8'd0);
    op("ctrl0", 8'hA2, 1, 0, 8'h02, g);
    for (int i = 0; i < 20; i++) begin
      push(8'(8'hC0 + i));
      op("wrap", 8'hA0, 0, 1, 0, g); chk("wrap_c", g, 8'(8'hC0 + i));
    end
    push(8'hAA); push(8'hBB); push(8'hCC);
    op("flush", 8'hA2, 1, 0, 8'h02, g);
    op("flush_st", 8'hA1, 0, 1, 0, g); chk("flush_st_c", g, 8'h01);
    for (int i = 0; i < 5; i++) push(8'(i));
    op("ie_thr0", 8'hA2, 1, 0, 8'h01, g);
    idle();
    chk("pre_rst_irq", {7'd0, irq}, 8'd1);
    @(negedge clk);
    #2 rst = 1;
    #1 chk("async_irq", {7'd0, irq}, 8'd0);
    chk("async_data", bus.slv2mst_data, 8'd0);
    model_reset();
    @(negedge clk) rst = 0;
    op("post_rst_pop", 8'hA0, 0, 1, 0, g); chk("post_rst_pop_c", g, 8'h00);
    op("post_rst_flags", 8'hA3, 0, 1, 0, g); chk("post_rst_flags_c", g, 8'h02);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a, d;
      logic w, r;
      a = ($urandom_range(0, 15) == 0) ? 8'($urandom) : {6'h28, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 2) == 0) a = 8'hA0;
      w = 1'($urandom);
      r = 1'($urandom);
      d = 8'($urandom);
      if (a == 8'hA2 && $urandom_range(0, 7) != 0) d[1] = 1'b0;
      op("rand", a, w, r, d, g);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
